// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD <-> binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DIGIT_MAX = 9;

    // 10^n as a 64-bit constant; used for the elaboration-time range check.
    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble per-digit correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    localparam logic [3:0] ADJ_THRESH = 4'((DIGIT_MAX + 1) / 2);

    // Pure combinational correction
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESH) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_bin_converter.sv
// Iterative BCD <-> binary converter.
// Mode 0 folds one BCD digit per cycle (acc*10 + digit), mode 1 runs
// double-dabble one input bit per cycle. Results are held until out_ready.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready=1
//   CONV  | one digit (mode 0) or one bit (mode 1) per cycle
//   DONE  | result held on out_*, waiting for out_ready
module bcd_bin_converter
    import bcd_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int BIN_W  = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      out_bin,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  out_err,
    output logic                  out_mode
);

    localparam int BCD_W    = 4 * DIGITS;
    localparam int STEP_MAX = (DIGITS > BIN_W) ? DIGITS : BIN_W;
    localparam int STEP_W   = $clog2(STEP_MAX + 1);

    localparam logic [STEP_W-1:0] LAST_DEC = STEP_W'(DIGITS - 1);
    localparam logic [STEP_W-1:0] LAST_BIN = STEP_W'(BIN_W - 1);

    // The binary side must be able to hold every DIGITS-digit decimal value.
    if (BIN_W < 64) begin : g_range_chk
        if ((64'd1 << BIN_W) < pow10(DIGITS)) begin : g_range_err
            $error("bcd_bin_converter: BIN_W too narrow for DIGITS");
        end
    end

    state_t               r_state;
    logic                 r_mode;
    logic [BCD_W-1:0]     r_src_bcd;
    logic [BIN_W-1:0]     r_src_bin;
    logic [BIN_W-1:0]     r_acc_bin;
    logic [BCD_W-1:0]     r_acc_bcd;
    logic                 r_err;
    logic [STEP_W-1:0]    r_step;

    logic                 r_out_valid;
    logic [BIN_W-1:0]     r_out_bin;
    logic [BCD_W-1:0]     r_out_bcd;
    logic                 r_out_err;
    logic                 r_out_mode;

    logic [3:0]           w_digit;
    logic [BIN_W-1:0]     w_acc_bin_next;
    logic [BCD_W-1:0]     w_adj_bcd;
    logic [BCD_W-1:0]     w_acc_bcd_next;
    logic                 w_err_now;
    logic                 w_last;

    // Digit-wise add-3 correction on the BCD accumulator
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc_bcd[4*g +: 4]),
            .o_digit (w_adj_bcd[4*g +: 4])
        );
    end

    // Next-step datapath for both modes; the operand registers shift so the
    // digit/bit being consumed is always at the top.
    always_comb begin
        w_digit        = r_src_bcd[BCD_W-1 -: 4];
        w_acc_bin_next = (r_acc_bin << 3) + (r_acc_bin << 1)
                       + {{(BIN_W-4){1'b0}}, w_digit};
        w_acc_bcd_next = {w_adj_bcd[BCD_W-2:0], r_src_bin[BIN_W-1]};
        w_err_now      = r_mode ? w_adj_bcd[BCD_W-1]
                                : (w_digit > 4'(DIGIT_MAX));
        w_last         = (r_step == (r_mode ? LAST_BIN : LAST_DEC));
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mode      <= 1'b0;
            r_src_bcd   <= '0;
            r_src_bin   <= '0;
            r_acc_bin   <= '0;
            r_acc_bcd   <= '0;
            r_err       <= 1'b0;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_out_bin   <= '0;
            r_out_bcd   <= '0;
            r_out_err   <= 1'b0;
            r_out_mode  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_mode    <= mode;
                        r_src_bcd <= in_bcd;
                        r_src_bin <= in_bin;
                        r_acc_bin <= '0;
                        r_acc_bcd <= '0;
                        r_err     <= 1'b0;
                        r_step    <= '0;
                        r_state   <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (r_mode) begin
                        r_acc_bcd <= w_acc_bcd_next;
                        r_src_bin <= r_src_bin << 1;
                    end else begin
                        r_acc_bin <= w_acc_bin_next;
                        r_src_bcd <= r_src_bcd << 4;
                    end
                    if (w_err_now) begin
                        r_err <= 1'b1;
                    end
                    r_step <= r_step + STEP_W'(1);
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_out_mode  <= r_mode;
                        r_out_err   <= r_err | w_err_now;
                        r_out_bin   <= r_mode ? '0 : w_acc_bin_next;
                        r_out_bcd   <= r_mode ? w_acc_bcd_next : '0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_bin   <= '0;
                        r_out_bcd   <= '0;
                        r_out_err   <= 1'b0;
                        r_out_mode  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign out_bin   = r_out_bin;
    assign out_bcd   = r_out_bcd;
    assign out_err   = r_out_err;
    assign out_mode  = r_out_mode;

endmodule

// File: tb/tb_bcd_bin_converter.sv
// Randomised bench for bcd_bin_converter against a decimal-arithmetic model.
module tb_bcd_bin_converter;

    localparam int DIGITS = 8;
    localparam int BIN_W  = 32;
    localparam longint unsigned DEC_LIMIT = 64'd100000000;

    logic                 clk;
    logic                 reset;
    logic                 mode;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*DIGITS-1:0]  in_bcd;
    logic [BIN_W-1:0]     in_bin;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_W-1:0]     out_bin;
    logic [4*DIGITS-1:0]  out_bcd;
    logic                 out_err;
    logic                 out_mode;

    int total;
    int bad;

    bcd_bin_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .in_bin    (in_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_bcd   (out_bcd),
        .out_err   (out_err),
        .out_mode  (out_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal value of the packed digits, each nibble taken at face value.
    function automatic longint unsigned model_bcd2bin(input logic [31:0] b);
        longint unsigned v;
        logic [31:0] t;
        t = b;
        v = 0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            v = v * 10 + longint'(t[4*d +: 4]);
        end
        return v % (64'd1 << BIN_W);
    endfunction

    function automatic bit model_bcd_err(input logic [31:0] b);
        logic [31:0] t;
        t = b;
        for (int d = 0; d < DIGITS; d++) begin
            if (t[4*d +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_bin2bcd(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        x = v % DEC_LIMIT;
        r = '0;
        for (int d = 0; d < DIGITS; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic run_req(input logic m, input logic [31:0] bcd, input logic [31:0] bin,
                           input int bp, input string tag);
        logic [31:0] e_bin;
        logic [31:0] e_bcd;
        logic        e_err;
        int          lat;
        bit          seen;
        if (m == 1'b0) begin
            e_bin = 32'(model_bcd2bin(bcd));
            e_bcd = '0;
            e_err = model_bcd_err(bcd);
        end else begin
            e_bin = '0;
            e_bcd = model_bin2bcd(longint'(bin));
            e_err = (longint'(bin) >= DEC_LIMIT);
        end
        check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
        mode     = m;
        in_bcd   = bcd;
        in_bin   = bin;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        lat  = 0;
        seen = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            in_valid = 1'($urandom);
            mode     = 1'($urandom);
            in_bcd   = $urandom;
            in_bin   = $urandom;
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat  = n;
                seen = 1'b1;
                break;
            end
        end
        check({tag, " seen out_valid"}, 64'(seen), 64'd1);
        check({tag, " latency"}, 64'(lat), (m ? 64'(BIN_W) : 64'(DIGITS)));
        check({tag, " out_bin"}, 64'(out_bin), 64'(e_bin));
        check({tag, " out_bcd"}, 64'(out_bcd), 64'(e_bcd));
        check({tag, " out_err"}, 64'(out_err), 64'(e_err));
        check({tag, " out_mode"}, 64'(out_mode), 64'(m));
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            #1;
            check({tag, " bp valid"}, 64'(out_valid), 64'd1);
            check({tag, " bp in_ready"}, 64'(in_ready), 64'd0);
            check({tag, " bp stable"}, {out_bin, out_bcd}, {e_bin, e_bcd});
            check({tag, " bp err/mode"}, {62'd0, out_err, out_mode}, {62'd0, e_err, m});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check({tag, " released valid"}, 64'(out_valid), 64'd0);
        check({tag, " released in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] rb;
        logic [31:0] rn;
        logic        rm;
        int          stale;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        in_bin    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {out_bin, out_bcd}, 64'd0);
        check("reset flags", {61'd0, out_valid, out_err, out_mode}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset in_ready", 64'(in_ready), 64'd1);

        run_req(1'b0, 32'h12345678, 32'h0, 0, "bcd 12345678");
        run_req(1'b1, 32'h0, 32'h05F5E0FF, 0, "bin 99999999");
        run_req(1'b1, 32'h0, 32'h05F5E100, 0, "bin 1e8");
        run_req(1'b0, 32'h0000001A, 32'h0, 0, "bcd 1A");
        run_req(1'b0, 32'h99999999, 32'h0, 5, "bcd backpressure");
        run_req(1'b1, 32'h0, 32'hFFFFFFFF, 2, "bin max");

        // Abort a mode-0 request while r_step is 4.
        mode     = 1'b0;
        in_bcd   = 32'h87654321;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort outputs", {out_bin, out_bcd}, 64'd0);
        check("abort flags", {61'd0, out_valid, out_err, out_mode}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort in_ready", 64'(in_ready), 64'd1);
        stale = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("abort no stale valid", 64'(stale), 64'd0);

        for (int k = 0; k < 40; k++) begin
            rm = 1'($urandom);
            rb = 32'h0;
            rn = 32'h0;
            if (rm == 1'b0) begin
                if ($urandom_range(3, 0) == 0) begin
                    rb = $urandom;
                end else begin
                    for (int d = 0; d < DIGITS; d++) rb[4*d +: 4] = 4'($urandom_range(9, 0));
                end
            end else begin
                if ($urandom_range(3, 0) == 0) rn = $urandom;
                else rn = $urandom % 32'd100000000;
            end
            run_req(rm, rb, rn, $urandom_range(3, 0), "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
